// File: rtl/noc_pkg.sv
// Shared definitions for the mesh router input port: flit type codes,
// output port codes, controller state encoding and header field layout.
package noc_pkg;

    // Flit type lives in the two MSBs of every flit.
    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } flitType_t;

    // Output port codes as understood by SwitchControl.
    typedef enum logic [2:0] {
        PORT_EAST  = 3'd0,
        PORT_WEST  = 3'd1,
        PORT_NORTH = 3'd2,
        PORT_SOUTH = 3'd3,
        PORT_LOCAL = 3'd4
    } portCode_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_FWD     = 3'd3,
        ST_RELIEVE = 3'd4
    } ctrlState_t;

    // Header layout: type in the top TYPE_W bits, destX directly below,
    // destY directly below destX.
    localparam int TYPE_W = 2;

    function automatic logic isHeadType(input flitType_t t);
        return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
    endfunction

    function automatic logic isTailType(input flitType_t t);
        return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
    endfunction

    // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
    function automatic portCode_t xyRoute(input int destX, input int destY,
                                          input int nodeX, input int nodeY);
        portCode_t p;
        if (destX > nodeX)      p = PORT_EAST;
        else if (destX < nodeX) p = PORT_WEST;
        else if (destY > nodeY) p = PORT_NORTH;
        else if (destY < nodeY) p = PORT_SOUTH;
        else                    p = PORT_LOCAL;
        return p;
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// Show-ahead flit buffer. The head entry is always visible on headData;
// full/empty are registered so the upstream ready never depends on pop.
module flit_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pushValid,
    input  logic [DATA_WIDTH-1:0] pushData,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] headData,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wrPtr;
    logic [AW-1:0]         rdPtr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         countNext;
    logic                  doPush;
    logic                  doPop;

    assign doPush   = pushValid & ~full;
    assign doPop    = pop & ~empty;
    assign headData = mem[rdPtr];

    // Occupancy after this cycle's push/pop; drives the registered flags.
    always_comb begin
        countNext = count;
        case ({doPush, doPop})
            2'b10:   countNext = count + CW'(1);
            2'b01:   countNext = count - CW'(1);
            default: countNext = count;
        endcase
    end

    // Storage is data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (doPush) wrPtr <= wrPtr + AW'(1);
            if (doPop)  rdPtr <= rdPtr + AW'(1);
            count <= countNext;
            full  <= (countNext == CW'(DEPTH));
            empty <= (countNext == '0);
        end
    end

endmodule

// File: rtl/input_port_controller.sv
// Input port front end of a mesh router: buffers flits, XY-routes each
// packet head, reserves the output through SwitchControl, streams the
// packet to the crossbar and releases the path after the tail.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | wait for a head at the FIFO front; discard stray body/tail
//   REQ     | one-cycle reserve pulse with the latched route
//   WAIT    | request held until SwitchControl grants
//   FWD     | path owned; FIFO head streamed until tail/single leaves
//   RELIEVE | one-cycle release pulse, nothing forwarded
module input_port_controller
    import noc_pkg::*;
#(
    parameter int N             = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int REQUEST_WIDTH = 3,
    parameter int FIFO_DEPTH    = 4,
    parameter int NODE_X        = 0,
    parameter int NODE_Y        = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    dataIn,
    input  logic                     validIn,
    output logic                     readyOut,
    output logic [DATA_WIDTH-1:0]    dataOut,
    output logic                     validOut,
    input  logic                     readyIn,
    output logic                     routeReserveRequestValid,
    output logic [REQUEST_WIDTH-1:0] routeReserveRequest,
    input  logic                     routeReserveStatus,
    output logic                     routeRelieve,
    output logic [7:0]               dropCount
);

    localparam int XW = (N > 1) ? $clog2(N) : 1;

    ctrlState_t            state;
    ctrlState_t            nextState;
    portCode_t             routeReg;
    portCode_t             routeCalc;
    logic [DATA_WIDTH-1:0] fifoHead;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  fifoPop;
    logic                  latchRoute;
    logic                  dropInc;
    flitType_t             headType;
    logic [XW-1:0]         destX;
    logic [XW-1:0]         destY;

    flit_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .pushValid (validIn),
        .pushData  (dataIn),
        .pop       (fifoPop),
        .headData  (fifoHead),
        .full      (fifoFull),
        .empty     (fifoEmpty)
    );

    assign readyOut = ~fifoFull;
    // Gated so stale buffer contents never leak out after reset.
    assign dataOut  = fifoEmpty ? '0 : fifoHead;

    assign headType  = flitType_t'(fifoHead[DATA_WIDTH-1 -: TYPE_W]);
    assign destX     = fifoHead[DATA_WIDTH-1-TYPE_W -: XW];
    assign destY     = fifoHead[DATA_WIDTH-1-TYPE_W-XW -: XW];
    assign routeCalc = xyRoute(int'(destX), int'(destY), NODE_X, NODE_Y);

    assign routeReserveRequest = REQUEST_WIDTH'(routeReg);

    // Next-state and per-state outputs.
    always_comb begin
        nextState                = state;
        fifoPop                  = 1'b0;
        validOut                 = 1'b0;
        routeReserveRequestValid = 1'b0;
        routeRelieve             = 1'b0;
        latchRoute               = 1'b0;
        dropInc                  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifoEmpty) begin
                    if (isHeadType(headType)) begin
                        latchRoute = 1'b1;
                        nextState  = ST_REQ;
                    end else begin
                        fifoPop = 1'b1;
                        dropInc = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                routeReserveRequestValid = 1'b1;
                nextState                = ST_WAIT;
            end
            ST_WAIT: begin
                if (routeReserveStatus) begin
                    nextState = ST_FWD;
                end
            end
            ST_FWD: begin
                validOut = ~fifoEmpty;
                fifoPop  = validOut & readyIn;
                if (fifoPop && isTailType(headType)) begin
                    nextState = ST_RELIEVE;
                end
            end
            ST_RELIEVE: begin
                routeRelieve = 1'b1;
                nextState    = ST_IDLE;
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

    // State register, route latch and saturating drop counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            routeReg  <= PORT_EAST;
            dropCount <= 8'd0;
        end else begin
            state <= nextState;
            if (latchRoute) begin
                routeReg <= routeCalc;
            end
            if (dropInc && (dropCount != 8'hFF)) begin
                dropCount <= dropCount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_input_port_controller.sv
// Scoreboard bench for input_port_controller at node (1,1) of a 4x4 mesh.
module tb_input_port_controller;

    localparam int DW = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] dataIn = '0;
    logic        validIn = 1'b0;
    logic        readyOut;
    logic [31:0] dataOut;
    logic        validOut;
    logic        readyIn = 1'b0;
    logic        reqValid;
    logic [2:0]  routeReq;
    logic        status = 1'b0;
    logic        routeRelieve;
    logic [7:0]  dropCount;

    int          nChecks = 0;
    int          nFails = 0;
    int          cyc = 0;
    int          tailCyc = -10;
    int          relieveCount = 0;
    logic        prevReq = 1'b0;
    logic        statusPrev = 1'b0;
    logic        grantEnable = 1'b0;
    int          grantDelay = 1;
    logic        pending = 1'b0;
    logic [31:0] expFlit;
    logic [31:0] dataQ[$];
    logic [2:0]  reqQ[$];

    input_port_controller #(
        .N(4), .DATA_WIDTH(DW), .REQUEST_WIDTH(3), .FIFO_DEPTH(4),
        .NODE_X(1), .NODE_Y(1)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .dataIn                   (dataIn),
        .validIn                  (validIn),
        .readyOut                 (readyOut),
        .dataOut                  (dataOut),
        .validOut                 (validOut),
        .readyIn                  (readyIn),
        .routeReserveRequestValid (reqValid),
        .routeReserveRequest      (routeReq),
        .routeReserveStatus       (status),
        .routeRelieve             (routeRelieve),
        .dropCount                (dropCount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mkFlit(input logic [1:0] t, input logic [1:0] x,
                                           input logic [1:0] y, input logic [25:0] p);
        return {t, x, y, p};
    endfunction

    function automatic logic [2:0] expRoute(input int x, input int y);
        if (x > 1) return 3'd0;
        if (x < 1) return 3'd1;
        if (y > 1) return 3'd2;
        if (y < 1) return 3'd3;
        return 3'd4;
    endfunction

    task automatic sendFlit(input logic [31:0] f, input logic expectFwd);
        int n;
        n = 0;
        if (expectFwd) dataQ.push_back(f);
        validIn = 1'b1;
        dataIn  = f;
        while (!readyOut && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) checkVal("push_timeout", n, 0);
        tick();
        validIn = 1'b0;
    endtask

    task automatic waitRelieve(input int target);
        int n;
        n = 0;
        while (relieveCount < target && n < 100) begin
            tick();
            n++;
        end
        checkVal("relieve_wait", relieveCount, target);
    endtask

    // SwitchControl stand-in: grant grantDelay cycles after the request pulse.
    always begin
        @(posedge clk);
        #1;
        if (!rst) begin
            pending = 1'b0;
        end else begin
            if (reqValid) pending = 1'b1;
            if (pending && grantEnable) begin
                pending = 1'b0;
                repeat (grantDelay) begin
                    @(posedge clk);
                    #1;
                end
                status = 1'b1;
                @(posedge clk);
                #1;
                status = 1'b0;
            end
        end
    end

    // Output monitor: scoreboard pops, pulse shape and latency checks.
    always @(negedge clk) begin
        if (rst) begin
            if (statusPrev) checkVal("fwd_lat", validOut, 1);
            if (validOut && readyIn) begin
                if (dataQ.size() == 0) begin
                    checkVal("data_unexp", dataQ.size(), 1);
                end else begin
                    expFlit = dataQ.pop_front();
                    checkVal("data", dataOut, expFlit);
                    if (expFlit[31]) tailCyc = cyc;
                end
            end
            if (reqValid) begin
                checkVal("req_pulse", prevReq, 0);
                if (reqQ.size() == 0) checkVal("route_unexp", reqQ.size(), 1);
                else checkVal("route", routeReq, reqQ.pop_front());
            end
            if (routeRelieve) begin
                relieveCount++;
                checkVal("relieve_lat", cyc, tailCyc + 1);
            end
            prevReq    = reqValid;
            statusPrev = status;
        end else begin
            prevReq    = 1'b0;
            statusPrev = 1'b0;
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_valid"}, validOut, 0);
        checkVal({tag, "_data"}, dataOut, 0);
        checkVal({tag, "_reqv"}, reqValid, 0);
        checkVal({tag, "_req"}, routeReq, 0);
        checkVal({tag, "_relieve"}, routeRelieve, 0);
        checkVal({tag, "_drop"}, dropCount, 0);
    endtask

    initial begin
        int n;
        int rc;
        repeat (3) tick();
        checkResetOutputs("rst0");
        rst = 1'b1;
        tick();
        checkVal("rst0_ready", readyOut, 1);

        // 1: reset while forwarding a packet that has no tail yet
        grantDelay  = 1;
        grantEnable = 1'b1;
        readyIn     = 1'b0;
        reqQ.push_back(3'd0);
        sendFlit(mkFlit(2'b01, 2'd3, 2'd0, 26'h0000AA), 1'b1);
        repeat (6) tick();
        checkVal("t1_fwd", validOut, 1);
        rc  = relieveCount;
        rst = 1'b0;
        #1;
        checkResetOutputs("t1_inrst");
        tick();
        rst = 1'b1;
        dataQ.delete();
        reqQ.delete();
        tick();
        checkResetOutputs("t1_after");
        repeat (3) tick();
        checkVal("t1_norelieve", relieveCount, rc);

        // 2: single-flit packet east, grant two cycles after request
        readyIn    = 1'b1;
        grantDelay = 2;
        reqQ.push_back(3'd0);
        sendFlit(mkFlit(2'b11, 2'd3, 2'd0, 26'h123456), 1'b1);
        waitRelieve(rc + 1);

        // 3: four-flit packet north with readyIn toggling
        grantDelay = 1;
        reqQ.push_back(3'd2);
        fork
            begin
                sendFlit(mkFlit(2'b01, 2'd1, 2'd2, 26'h000301), 1'b1);
                sendFlit(mkFlit(2'b00, 2'd0, 2'd0, 26'h000302), 1'b1);
                sendFlit(mkFlit(2'b00, 2'd3, 2'd3, 26'h000303), 1'b1);
                sendFlit(mkFlit(2'b10, 2'd2, 2'd1, 26'h000304), 1'b1);
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    readyIn = ~readyIn;
                    tick();
                end
            end
        join
        readyIn = 1'b1;
        waitRelieve(rc + 2);
        checkVal("t3_drained", dataQ.size(), 0);

        // 4: local destination, grant withheld for 10 cycles
        grantEnable = 1'b0;
        reqQ.push_back(3'd4);
        sendFlit(mkFlit(2'b01, 2'd1, 2'd1, 26'h000401), 1'b1);
        repeat (2) tick();
        for (int i = 0; i < 10; i++) begin
            checkVal("t4_novalid", validOut, 0);
            checkVal("t4_req_stable", routeReq, 4);
            tick();
        end
        grantEnable = 1'b1;
        sendFlit(mkFlit(2'b10, 2'd0, 2'd0, 26'h000402), 1'b1);
        waitRelieve(rc + 3);

        // 5: stray body/tail dropped, then a normal packet west
        sendFlit(mkFlit(2'b00, 2'd2, 2'd2, 26'h000501), 1'b0);
        sendFlit(mkFlit(2'b10, 2'd2, 2'd2, 26'h000502), 1'b0);
        repeat (4) tick();
        checkVal("t5_drop", dropCount, 2);
        checkVal("t5_norelieve", relieveCount, rc + 3);
        reqQ.push_back(expRoute(0, 1));
        sendFlit(mkFlit(2'b01, 2'd0, 2'd1, 26'h000503), 1'b1);
        sendFlit(mkFlit(2'b00, 2'd0, 2'd0, 26'h000504), 1'b1);
        sendFlit(mkFlit(2'b10, 2'd0, 2'd0, 26'h000505), 1'b1);
        waitRelieve(rc + 4);

        // 6: fill to full, refused push, push+pop while full
        readyIn     = 1'b0;
        grantEnable = 1'b0;
        reqQ.push_back(expRoute(1, 0));
        sendFlit(mkFlit(2'b01, 2'd1, 2'd0, 26'h000601), 1'b1);
        sendFlit(mkFlit(2'b00, 2'd0, 2'd0, 26'h000602), 1'b1);
        sendFlit(mkFlit(2'b00, 2'd0, 2'd0, 26'h000603), 1'b1);
        sendFlit(mkFlit(2'b00, 2'd0, 2'd0, 26'h000604), 1'b1);
        checkVal("t6_full", readyOut, 0);
        validIn = 1'b1;
        dataIn  = mkFlit(2'b00, 2'd0, 2'd0, 26'h0006FF);
        tick();
        checkVal("t6_refuse", readyOut, 0);
        grantEnable = 1'b1;
        n = 0;
        while (!validOut && n < 20) begin
            tick();
            n++;
        end
        checkVal("t6_fwd", validOut, 1);
        readyIn = 1'b1;
        checkVal("t6_pushpop", readyOut, 0);
        tick();
        readyIn = 1'b0;
        validIn = 1'b0;
        checkVal("t6_freed", readyOut, 1);
        readyIn = 1'b1;
        sendFlit(mkFlit(2'b10, 2'd0, 2'd0, 26'h000605), 1'b1);
        waitRelieve(rc + 5);

        // 7: drop counter saturates
        for (int i = 0; i < 260; i++) begin
            sendFlit(mkFlit(2'b00, 2'(i), 2'(i >> 2), 26'(i)), 1'b0);
        end
        repeat (3) tick();
        checkVal("t7_drop_sat", dropCount, 255);

        repeat (5) tick();
        checkVal("sb_data_empty", dataQ.size(), 0);
        checkVal("sb_req_empty", reqQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
